// File: rtl/sr_latch_writer.sv
// Clocked write sequencer for a gated NAND SR latch: setup / enable pulse / hold, optional readback.
// Define SR_WRITER_VERIFY_EN to compile in the q_in synchronizer, the VERIFY state and err reporting.
module sr_latch_writer #(
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    input  logic       req_data,
    output logic       req_ready,
    input  logic       q_in,
    output logic       latch_s,
    output logic       latch_r,
    output logic       latch_en,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [2:0] dbg_state_o
);

    // Handshake: a request is taken on a rising edge where req_valid && req_ready;
    // req_ready is high only in IDLE and requests seen while it is low are dropped.
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETUP  = 3'd1;
    localparam logic [2:0] ST_PULSE  = 3'd2;
    localparam logic [2:0] ST_HOLD   = 3'd3;
`ifdef SR_WRITER_VERIFY_EN
    localparam logic [2:0] ST_VERIFY = 3'd4;
`endif
    localparam logic [2:0] ST_DONE   = 3'd5;

    localparam int MAX_SP  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int MAX_SPH = (MAX_SP > HOLD_CYC) ? MAX_SP : HOLD_CYC;
`ifdef SR_WRITER_VERIFY_EN
    localparam int MAX_ALL = (MAX_SPH > 3) ? MAX_SPH : 3;
`else
    localparam int MAX_ALL = MAX_SPH;
`endif
    localparam int CW = $clog2(MAX_ALL) + 1;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          data_q, data_d;
    logic          accept;
    logic          drive_sr;

    logic ready_q, s_q, r_q, en_q, busy_q, done_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    accept  = 1'b1;
                    data_d  = req_data;
                    state_d = ST_SETUP;
                    cnt_d   = CW'(SETUP_CYC - 1);
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = ST_PULSE;
                    cnt_d   = CW'(PULSE_CYC - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_PULSE: begin
                if (cnt_q == '0) begin
                    state_d = ST_HOLD;
                    cnt_d   = CW'(HOLD_CYC - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
`ifdef SR_WRITER_VERIFY_EN
                    state_d = ST_VERIFY;
                    cnt_d   = CW'(2);
`else
                    state_d = ST_DONE;
                    cnt_d   = '0;
`endif
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`ifdef SR_WRITER_VERIFY_EN
            ST_VERIFY: begin
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered pins line up with state_q.
    assign drive_sr = (state_d == ST_SETUP) || (state_d == ST_PULSE) || (state_d == ST_HOLD);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            data_q  <= 1'b0;
            ready_q <= 1'b1;
            s_q     <= 1'b0;
            r_q     <= 1'b0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            ready_q <= (state_d == ST_IDLE);
            s_q     <= drive_sr & data_d;
            r_q     <= drive_sr & ~data_d;
            en_q    <= (state_d == ST_PULSE);
            busy_q  <= (state_d != ST_IDLE);
            done_q  <= (state_d == ST_DONE);
        end
    end

`ifdef SR_WRITER_VERIFY_EN
    logic sync1_q, sync2_q;
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (accept) begin
            err_d = 1'b0;
        end else if ((state_q == ST_VERIFY) && (cnt_q == '0)) begin
            err_d = (sync2_q != data_q);
        end
    end

    // q_in is asynchronous to clk; two flops before it is compared.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sync1_q <= q_in;
            sync2_q <= sync1_q;
            err_q   <= err_d;
        end
    end

    assign err = err_q;
`else
    logic unused_q_in;
    assign unused_q_in = q_in;
    assign err         = 1'b0;
`endif

    assign req_ready   = ready_q;
    assign latch_s     = s_q;
    assign latch_r     = r_q;
    assign latch_en    = en_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sr_latch_writer.sv
// Bench for sr_latch_writer: default-parameter instance plus a 2/3/2 instance, each driving a latch model.
module tb_sr_latch_writer;

  localparam int W = 42;

`ifdef SR_WRITER_VERIFY_EN
  localparam bit VER   = 1'b1;
  localparam int DONE0 = 8;
  localparam int DONE1 = 11;
  localparam int GAP0  = 7;
`else
  localparam bit VER   = 1'b0;
  localparam int DONE0 = 5;
  localparam int DONE1 = 8;
  localparam int GAP0  = 4;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rstn = 2'b00;
  logic [1:0] valid = 2'b00;
  logic [1:0] data = 2'b00;
  logic [1:0] ready, s, r, en, busy, done, err, q_in;
  logic [2:0] dbg0, dbg1;

  logic [1:0] lq = 2'b00;
  logic [1:0] stuck = 2'b00;

  sr_latch_writer dut0 (
    .clk(clk), .rst_n(rstn[0]), .req_valid(valid[0]), .req_data(data[0]),
    .req_ready(ready[0]), .q_in(q_in[0]), .latch_s(s[0]), .latch_r(r[0]),
    .latch_en(en[0]), .busy(busy[0]), .done(done[0]), .err(err[0]), .dbg_state_o(dbg0)
  );

  sr_latch_writer #(.SETUP_CYC(2), .PULSE_CYC(3), .HOLD_CYC(2)) dut1 (
    .clk(clk), .rst_n(rstn[1]), .req_valid(valid[1]), .req_data(data[1]),
    .req_ready(ready[1]), .q_in(q_in[1]), .latch_s(s[1]), .latch_r(r[1]),
    .latch_en(en[1]), .busy(busy[1]), .done(done[1]), .err(err[1]), .dbg_state_o(dbg1)
  );

  // Gated SR latch behaviour: transparent while En is high.
  always @(s, r, en) begin
    for (int k = 0; k < 2; k++) begin
      if (en[k] && s[k]) lq[k] = 1'b1;
      else if (en[k] && r[k]) lq[k] = 1'b0;
    end
  end
  assign q_in = lq & ~stuck;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Record: {err, q, done_cyc, en_first, en_last, sr_first, sr_last}
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];

  function automatic logic [W-1:0] exp_rec(input int k, input logic d, input logic stk);
    logic q, e;
    q = stk ? 1'b0 : d;
    e = VER && (q != d);
    if (k == 0) return {e, q, 8'(DONE0), 8'd2, 8'd3, 8'd1, 8'd4};
    else        return {e, q, 8'(DONE1), 8'd3, 8'd5, 8'd1, 8'd7};
  endfunction

  int tcyc[2], cyc[2], enf[2], enl[2], srf[2], srl[2];
  int acc_t[2], acc_gap[2], en_gap[2], last_en_t[2], done_cnt[2];
  logic [1:0] active = 2'b00;
  logic [1:0] prev_en = 2'b00, prev_s = 2'b00, prev_r = 2'b00;
  int overlap_viol = 0;
  int change_viol = 0;

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic [W-1:0] rec;
      tcyc[k]++;
      if (s[k] && r[k]) overlap_viol++;
      if (en[k] && prev_en[k] && ((s[k] != prev_s[k]) || (r[k] != prev_r[k]))) change_viol++;
      if (en[k] && !prev_en[k]) en_gap[k] = tcyc[k] - last_en_t[k] - 1;
      if (en[k]) last_en_t[k] = tcyc[k];
      if (!rstn[k]) begin
        active[k] = 1'b0;
      end else if (active[k]) begin
        cyc[k]++;
        if (en[k]) begin
          if (enf[k] == 0) enf[k] = cyc[k];
          enl[k] = cyc[k];
        end
        if (s[k] || r[k]) begin
          if (srf[k] == 0) srf[k] = cyc[k];
          srl[k] = cyc[k];
        end
        if (done[k]) begin
          done_cnt[k]++;
          active[k] = 1'b0;
          if ((k == 0 && exp_q0.size() == 0) || (k == 1 && exp_q1.size() == 0)) begin
            check($sformatf("dut%0d_done_without_expectation", k), 1, 0);
          end else begin
            rec = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            check($sformatf("dut%0d_done_cycle", k), cyc[k], int'(rec[39:32]));
            check($sformatf("dut%0d_en_first", k), enf[k], int'(rec[31:24]));
            check($sformatf("dut%0d_en_last", k), enl[k], int'(rec[23:16]));
            check($sformatf("dut%0d_sr_first", k), srf[k], int'(rec[15:8]));
            check($sformatf("dut%0d_sr_last", k), srl[k], int'(rec[7:0]));
            check($sformatf("dut%0d_err", k), int'(err[k]), int'(rec[41]));
            check($sformatf("dut%0d_latch_q", k), int'(q_in[k]), int'(rec[40]));
          end
        end
      end else if (done[k]) begin
        done_cnt[k]++;
        check($sformatf("dut%0d_unexpected_done", k), 1, 0);
      end
      if (rstn[k] && valid[k] && ready[k]) begin
        if (acc_t[k] != 0) acc_gap[k] = tcyc[k] - acc_t[k];
        acc_t[k] = tcyc[k];
        active[k] = 1'b1;
        cyc[k] = 0; enf[k] = 0; enl[k] = 0; srf[k] = 0; srl[k] = 0;
      end
      prev_en[k] = en[k];
      prev_s[k]  = s[k];
      prev_r[k]  = r[k];
    end
  end

  // Called at posedge+1; returns at posedge+1 of cycle 1 of the accepted write.
  task automatic issue(input int k, input logic d);
    logic got;
    int n;
    if (k == 0) exp_q0.push_back(exp_rec(0, d, stuck[0]));
    else        exp_q1.push_back(exp_rec(1, d, stuck[1]));
    valid[k] = 1'b1;
    data[k]  = d;
    n = 0;
    got = 1'b0;
    while (!got && n < 100) begin
      @(negedge clk);
      got = ready[k];
      @(posedge clk);
      #1;
      n++;
    end
    valid[k] = 1'b0;
    if (!got) check($sformatf("dut%0d_accept_timeout", k), 0, 1);
  endtask

  task automatic wait_idle(input int k);
    int n;
    n = 0;
    while (((k == 0) ? exp_q0.size() : exp_q1.size()) != 0 && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 60) begin
      check($sformatf("dut%0d_done_timeout", k), 0, 1);
      if (k == 0) exp_q0.delete(); else exp_q1.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc;
    // Reset both instances for 3 cycles
    rstn = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    rstn = 2'b11;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("dut%0d_rst_ready", k), int'(ready[k]), 1);
      check($sformatf("dut%0d_rst_s", k), int'(s[k]), 0);
      check($sformatf("dut%0d_rst_r", k), int'(r[k]), 0);
      check($sformatf("dut%0d_rst_en", k), int'(en[k]), 0);
      check($sformatf("dut%0d_rst_busy", k), int'(busy[k]), 0);
      check($sformatf("dut%0d_rst_done", k), int'(done[k]), 0);
      check($sformatf("dut%0d_rst_err", k), int'(err[k]), 0);
    end
    check("dut0_rst_state", int'(dbg0), 0);
    @(posedge clk);
    #1;

    // Set write with defaults
    issue(0, 1'b1);
    @(negedge clk);
    check("dut0_busy_cycle1", int'(busy[0]), 1);
    check("dut0_ready_cycle1", int'(ready[0]), 0);
    @(posedge clk);
    #1;
    wait_idle(0);

    // Reset write followed by a set held valid through busy
    issue(0, 1'b0);
    issue(0, 1'b1);
    wait_idle(0);
    check("dut0_b2b_accept_spacing", acc_gap[0], DONE0 + 1);
    check("dut0_b2b_en_low_gap", en_gap[0], GAP0);

    // Stuck latch readback, err sticky until next acceptance
    stuck[0] = 1'b1;
    issue(0, 1'b1);
    wait_idle(0);
    repeat (3) begin
      @(negedge clk);
      check("dut0_err_sticky", int'(err[0]), int'(VER));
    end
    @(posedge clk);
    #1;
    stuck[0] = 1'b0;
    issue(0, 1'b1);
    @(negedge clk);
    check("dut0_err_cleared_on_accept", int'(err[0]), 0);
    @(posedge clk);
    #1;
    wait_idle(0);

    // Reset during the enable pulse
    issue(0, 1'b1);
    @(posedge clk);
    #1;
    rstn[0] = 1'b0;
    exp_q0.delete();
    dc = done_cnt[0];
    @(posedge clk);
    #1;
    @(negedge clk);
    check("dut0_midrst_s", int'(s[0]), 0);
    check("dut0_midrst_r", int'(r[0]), 0);
    check("dut0_midrst_en", int'(en[0]), 0);
    check("dut0_midrst_busy", int'(busy[0]), 0);
    check("dut0_midrst_ready", int'(ready[0]), 1);
    @(posedge clk);
    #1;
    rstn[0] = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("dut0_midrst_no_done", done_cnt[0], dc);
    check("dut0_midrst_ready_after", int'(ready[0]), 1);

    // Stretched timing instance
    issue(1, 1'b1);
    wait_idle(1);
    issue(1, 1'b0);
    wait_idle(1);

    check("s_and_r_overlap_cycles", overlap_viol, 0);
    check("sr_change_during_en_cycles", change_viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sr_latch_writer.md
# sr_latch_writer

Clocked driver for the gated SR latch. It accepts one-bit write requests over a valid/ready handshake and drives the latch's `S`, `R` and `En` inputs in a fixed setup / enable-pulse / hold sequence, with S and R never both high. When compiled in, it reads back the latch `Q` through a synchronizer and flags a mismatch. It sits between synchronous control logic and the asynchronous NAND-based storage cells, which have multi-ns gate delays.

## Interface

Parameters:
- `SETUP_CYC`, default 1: cycles S/R are stable with En low before the pulse. Minimum 1.
- `PULSE_CYC`, default 2: cycles En is held high. Minimum 1.
- `HOLD_CYC`, default 1: cycles S/R stay stable after En falls. Minimum 1.

Ports:
- `clk`, input, 1: sole clock; all state updates on the rising edge.
- `rst_n`, input, 1: synchronous, active-low reset.
- `req_valid`, input, 1: write request present.
- `req_data`, input, 1: value to store (1 → set, 0 → reset).
- `req_ready`, output, 1: block is idle and can accept a request.
- `q_in`, input, 1: latch `Q`, asynchronous to `clk`.
- `latch_s`, output, 1: drives latch S.
- `latch_r`, output, 1: drives latch R.
- `latch_en`, output, 1: drives latch En.
- `busy`, output, 1: a write is in progress (any state other than IDLE).
- `done`, output, 1: one-cycle pulse at write completion.
- `err`, output, 1: readback mismatch, valid in the `done` cycle. Sticky until the next acceptance.

## Operation

- States: IDLE → SETUP → PULSE → HOLD → VERIFY → DONE → IDLE. VERIFY exists only with the macro (see Configuration).
- IDLE:
  - `req_ready`=1; S=R=En=0.
  - On `req_valid && req_ready`: capture `req_data` into `data_q`, clear `err`, go to SETUP.
- SETUP: S=`data_q`, R=~`data_q`, En=0 for SETUP_CYC cycles.
- PULSE: S/R unchanged, En=1 for PULSE_CYC cycles.
- HOLD: S/R unchanged, En=0 for HOLD_CYC cycles.
- After HOLD, S=R=0 for the rest of the write.
- VERIFY:
  - Lasts 3 cycles: 2 synchronizer stages plus 1 compare.
  - In the last cycle, register `err` = (`q_sync` != `data_q`).
- DONE: `done`=1 for one cycle, then go to IDLE.
- A single down-counter, width $clog2(max param)+1, is loaded on each state entry.
- Invariants:
  - `latch_s && latch_r` is never 1.
  - En is high only in PULSE.
  - S/R never change while En is high.
- Requests presented while `req_ready`=0 are ignored; they are not queued.
- Reset mid-operation: on the reset edge the state goes to IDLE and S=R=En=0, `done`=0, `err`=0, `busy`=0, `req_ready`=1 from the next cycle. The latch keeps whatever value it reached; no cleanup pulse is issued.

## Timing

- All outputs are registered.
- Reset values: `req_ready`=1, `latch_s`=0, `latch_r`=0, `latch_en`=0, `busy`=0, `done`=0, `err`=0, synchronizer flops=0.
- Cycles are numbered after the acceptance edge (cycle 1 = first SETUP cycle).
  - En high in cycles SETUP_CYC+1 … SETUP_CYC+PULSE_CYC.
  - `done` high in cycle N = SETUP_CYC+PULSE_CYC+HOLD_CYC+V+1, where V=3 with verify and V=0 without.
  - Defaults: N=8 with verify, N=5 without.
- `req_ready` returns high in cycle N+1, so back-to-back requests are accepted on the edge ending cycle N+1.
- Throughput: one write per N+1 cycles.
- `busy` is high in cycles 1 … N.
- Nanosecond gate timing is the latch's concern. PULSE_CYC×Tclk must exceed the latch's worst-case NAND settle (two gate delays through the cross-coupled pair plus the input gate).

## Configuration

- `SR_WRITER_VERIFY_EN` defined:
  - The 2-flop synchronizer on `q_in` and the VERIFY state are compiled in.
  - `err` reports the readback result.
- Not defined:
  - No synchronizer and no VERIFY state; HOLD goes directly to DONE.
  - `q_in` is unused and `err` is tied to 0.
  - Latency N drops by 3.

## Test plan

- Reset: hold `rst_n`=0 for 3 cycles, then release → all outputs at their reset values, `req_ready`=1.
- Set write, defaults, latch model attached, verify on: `req_data`=1 → S=1/R=0 from cycle 1, En high in cycles 2–3, S=0 from cycle 5, `done` in cycle 8, `err`=0, Q=1.
- Reset write followed by back-to-back set: `req_data`=0, then 1 held valid → second acceptance on the edge ending cycle 9. En pulses are separated by ≥6 low cycles. Q ends at 1.
- Stuck latch: `q_in` forced to 0, `req_data`=1 → `done` in cycle 8 with `err`=1. `err` stays 1 until the next acceptance, then clears.
- Mid-operation reset: assert `rst_n`=0 during cycle 2 (En high) → S=R=En=0 the next cycle, no `done` pulse, `req_ready`=1 after release.
- Macro off, SETUP_CYC=2, PULSE_CYC=3, HOLD_CYC=2 → En high in cycles 3–5, `done` in cycle 8, `err` always 0. Across all scenarios, assert that S&R is never 1 and that S/R never change while En=1.
